// File: rtl/uart_baud_gen.sv
// Baud-rate generator: fractional prescaler producing a 16x oversample tick,
// plus the per-bit and half-bit strobes for the TX/RX engines.
module uart_baud_gen #(
    parameter logic [15:0] RESET_DIV  = 16'd1,
    parameter logic [3:0]  RESET_FRAC = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [15:0] div_i,
    input  logic [3:0]  frac_i,
    input  logic        div_load_i,
    input  logic        restart_i,
    output logic        oversample_tick_o,
    output logic        baud_rate_edge_o,
    output logic        double_rate_edge_o,
    output logic        div_zero_o
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned PRE_W = 17;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OS_W = 4;

    // Divisor shadow, only updated by an explicit load
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    // Prescale counter, fractional accumulator, stretch flag, oversample count
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [OS_W-1:0]   os_q, os_d;
    // Previous-cycle enable, used to detect the 0->1 enable edge
    logic              en_q;

    logic [PRE_W-1:0]  period_last;
    logic [FRAC_W:0]   acc_sum;
    logic              div_zero;
    logic              realign;
    logic              run;
    logic              tick;

    // Last count of the current period is div_q + ext_q - 1
    always_comb begin
        period_last = PRE_W'(div_q) + PRE_W'(ext_q) - PRE_W'(1);
    end

    // Qualify counting: any stall, realignment or reset suppresses strobes
    always_comb begin
        div_zero = (div_q == '0);
        realign  = div_load_i | restart_i;
        // The first enabled cycle is treated like a realignment so the first
        // tick lands div_q cycles after it, matching the load latency.
        run      = enable_i & en_q & ~div_zero & ~realign & ~rst_i;
        tick     = run & (pre_q == period_last);
        acc_sum  = (FRAC_W+1)'(acc_q) + (FRAC_W+1)'(frac_q);
    end

    // Strobe decode from the registered oversample count
    always_comb begin
        oversample_tick_o  = tick;
        baud_rate_edge_o   = tick & (os_q == 4'd15);
        double_rate_edge_o = tick & (os_q[2:0] == 3'd7);
        div_zero_o         = div_zero;
    end

    // Next-state logic for divisor shadow and counters
    always_comb begin
        div_d  = div_q;
        frac_d = frac_q;
        pre_d  = pre_q;
        acc_d  = acc_q;
        ext_d  = ext_q;
        os_d   = os_q;

        if (div_load_i) begin
            div_d  = div_i;
            frac_d = frac_i;
        end

        if (!run) begin
            // Stalled, disabled, first enabled cycle or realign: restart phase
            pre_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
            os_d  = '0;
        end else if (tick) begin
            pre_d = '0;
            acc_d = acc_sum[FRAC_W-1:0];
            ext_d = acc_sum[FRAC_W];
            os_d  = os_q + OS_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= RESET_DIV;
            frac_q <= RESET_FRAC;
            pre_q  <= '0;
            acc_q  <= '0;
            ext_q  <= 1'b0;
            os_q   <= '0;
            en_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            frac_q <= frac_d;
            pre_q  <= pre_d;
            acc_q  <= acc_d;
            ext_q  <= ext_d;
            os_q   <= os_d;
            en_q   <= enable_i;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: cycle-numbered stimulus, strobe logging.
module tb_uart_baud_gen;

    logic        clk;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] div_i;
    logic [3:0]  frac_i;
    logic        div_load_i;
    logic        restart_i;
    logic        oversample_tick_o;
    logic        baud_rate_edge_o;
    logic        double_rate_edge_o;
    logic        div_zero_o;

    int errors = 0;
    int checks = 0;
    int cyc = -1;
    int L;
    int R;
    int E;
    logic t, b, d, z;
    int tq[$];
    int bq[$];
    int dq[$];

    uart_baud_gen dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .div_i             (div_i),
        .frac_i            (frac_i),
        .div_load_i        (div_load_i),
        .restart_i         (restart_i),
        .oversample_tick_o (oversample_tick_o),
        .baud_rate_edge_o  (baud_rate_edge_o),
        .double_rate_edge_o(double_rate_edge_o),
        .div_zero_o        (div_zero_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Move into the next cycle; inputs driven after this apply to cycle cyc
    task automatic cyc_start();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sample outputs once the cycle's inputs have settled
    task automatic look();
        #1;
        t = oversample_tick_o;
        b = baud_rate_edge_o;
        d = double_rate_edge_o;
        z = div_zero_o;
    endtask

    task automatic clear_log();
        tq.delete();
        bq.delete();
        dq.delete();
    endtask

    // Run n cycles with one-shot strobes released, logging strobe cycles
    task automatic run_log(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_start();
            div_load_i = 1'b0;
            restart_i  = 1'b0;
            look();
            if (t === 1'b1) tq.push_back(cyc);
            if (d === 1'b1) dq.push_back(cyc);
            if (b === 1'b1) begin
                bq.push_back(cyc);
                chk("baud_with_double", int'(d), 1);
            end
        end
    endtask

    task automatic load(input logic [15:0] dv, input logic [3:0] fr);
        cyc_start();
        div_i      = dv;
        frac_i     = fr;
        div_load_i = 1'b1;
        look();
        L = cyc;
        chk("load_cycle_no_tick", int'(t), 0);
    endtask

    initial begin
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        div_i      = 16'd0;
        frac_i     = 4'd0;
        div_load_i = 1'b0;
        restart_i  = 1'b0;

        // Reset: cycles 0..2
        cyc_start(); look();
        cyc_start(); look();
        chk("rst_tick", int'(t), 0);
        chk("rst_baud", int'(b), 0);
        chk("rst_double", int'(d), 0);
        chk("rst_div_zero", int'(z), 0);
        cyc_start(); look();

        // Enable edge at cycle 3 with reset divisor 1: first tick at 4
        cyc_start();
        rst_i    = 1'b0;
        enable_i = 1'b1;
        look();
        chk("en_edge_no_tick", int'(t), 0);
        cyc_start(); look();
        chk("en_first_tick", int'(t), 1);
        for (int i = 5; i < 10; i++) begin
            cyc_start(); look();
        end

        // D=4, F=0 loaded at cycle 10
        load(16'd4, 4'd0);
        chk("t1_load_cycle", L, 10);
        clear_log();
        run_log(140);
        chk("t1_tick_count", tq.size(), 35);
        chk("t1_tick0", tq[0], 14);
        chk("t1_tick1", tq[1], 18);
        chk("t1_dbl0", dq[0], 42);
        chk("t1_dbl1", dq[1], 74);
        chk("t1_baud0", bq[0], 74);
        chk("t1_baud1", bq[1], 138);

        // D=1, F=0
        load(16'd1, 4'd0);
        clear_log();
        run_log(40);
        chk("t2_tick_count", tq.size(), 40);
        chk("t2_tick0", tq[0], L + 1);
        chk("t2_dbl0", dq[0], L + 8);
        chk("t2_dbl1", dq[1], L + 16);
        chk("t2_baud0", bq[0], L + 16);
        chk("t2_baud1", bq[1], L + 32);

        // D=2, F=8; divisor input changed afterwards without a load
        load(16'd2, 4'd8);
        clear_log();
        run_log(1);
        div_i  = 16'd7;
        frac_i = 4'd0;
        run_log(99);
        chk("t3_tick0", tq[0], L + 2);
        chk("t3_tick1", tq[1], L + 4);
        chk("t3_tick2", tq[2], L + 7);
        chk("t3_tick3", tq[3], L + 9);
        chk("t3_tick4", tq[4], L + 12);
        chk("t3_baud0", bq[0], L + 39);
        chk("t3_baud1", bq[1], L + 79);

        // Restart mid-bit with D=4: os_q is 9 after the tick at L+36
        load(16'd4, 4'd0);
        clear_log();
        run_log(39);
        chk("t4_tick8", tq[8], L + 36);
        chk("t4_tick_count", tq.size(), 9);
        cyc_start();
        restart_i = 1'b1;
        look();
        R = cyc;
        chk("t4_restart_no_tick", int'(t), 0);
        clear_log();
        run_log(70);
        chk("t4_tick0", tq[0], R + 4);
        chk("t4_dbl0", dq[0], R + 32);
        chk("t4_baud0", bq[0], R + 64);

        // Divisor zero stalls the generator
        load(16'd0, 4'd0);
        chk("t5_div_zero_load_cycle", int'(z), 0);
        clear_log();
        run_log(1);
        chk("t5_div_zero_set", int'(z), 1);
        run_log(999);
        chk("t5_no_ticks", tq.size(), 0);
        chk("t5_no_baud", bq.size(), 0);
        chk("t5_no_double", dq.size(), 0);
        chk("t5_div_zero_hold", int'(z), 1);

        // D=3 after stall
        load(16'd3, 4'd0);
        clear_log();
        run_log(1);
        chk("t5_div_zero_clear", int'(z), 0);
        run_log(36);
        chk("t5_tick0", tq[0], L + 3);
        chk("t6_tick11", tq[11], L + 36);

        // Enable dropped while os_q is 12, raised 20 cycles later
        cyc_start();
        enable_i = 1'b0;
        look();
        chk("t6_disable_no_tick", int'(t), 0);
        clear_log();
        run_log(19);
        chk("t6_off_ticks", tq.size(), 0);
        chk("t6_off_baud", bq.size(), 0);
        cyc_start();
        enable_i = 1'b1;
        look();
        E = cyc;
        chk("t6_reen_delay", E - L, 58);
        chk("t6_reen_no_tick", int'(t), 0);
        clear_log();
        run_log(62);
        chk("t6_tick0", tq[0], E + 3);
        chk("t6_tick_count", tq.size(), 20);
        chk("t6_baud0", bq[0], E + 48);

        // Reset in a cycle that would otherwise tick
        cyc_start();
        rst_i = 1'b1;
        look();
        chk("t7_rst_tick_masked", int'(t), 0);
        chk("t7_rst_baud", int'(b), 0);
        cyc_start();
        rst_i = 1'b0;
        look();
        chk("t7_post_rst_tick", int'(t), 0);
        chk("t7_post_rst_double", int'(d), 0);
        chk("t7_post_rst_div_zero", int'(z), 0);
        cyc_start(); look();
        chk("t7_reset_div_tick", int'(t), 1);
        cyc_start(); look();
        chk("t7_reset_div_tick2", int'(t), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=%0d expected=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
